// File: rtl/dual_rail_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dual_rail_pkg
// Description : Shared types and helpers for the dual-rail monitor.
//               Provides the monitor state encoding and the run-counter width
//               helper used by the top level.
// Revision    : 1.0  initial release
// ============================================================================
package dual_rail_pkg;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2,
    ST_UNUSED  = 2'd3
  } state_e;

  localparam int DEF_FAULT_THRESH = 4;

  // Run counter must be able to hold the value FAULT_THRESH.
  function automatic int run_cnt_w(input int thresh);
    return $clog2(thresh + 1);
  endfunction

  localparam int DEF_RUN_CNT_W = run_cnt_w(DEF_FAULT_THRESH);

endpackage : dual_rail_pkg
`default_nettype wire

// File: rtl/dual_rail_monitor_if.sv
`default_nettype none
// ============================================================================
// Interface   : dual_rail_monitor_if
// Description : Bundles the rail inputs, control inputs and decoded/status
//               outputs of the dual-rail monitor.
//               master : drives rails/init_value/clear_fault, observes status
//               slave  : the monitor itself
//   rail_p, rail_n  dual-rail pair (async to clk)
//   init_value      reset load value for data and synchronisers
//   clear_fault     single-cycle request to leave FAULT
//   data_q          decoded data bit
//   data_valid      state == OK
//   fault           state == FAULT
//   state           OK=0, SUSPECT=1, FAULT=2
//   err_count       saturating count of FAULT entries
// Revision    : 1.0  initial release
// ============================================================================
interface dual_rail_monitor_if #(
  parameter int CNT_W = 8
);
  logic             rail_p;
  logic             rail_n;
  logic             init_value;
  logic             clear_fault;
  logic             data_q;
  logic             data_valid;
  logic             fault;
  logic [1:0]       state;
  logic [CNT_W-1:0] err_count;

  modport master (
    output rail_p, rail_n, init_value, clear_fault,
    input  data_q, data_valid, fault, state, err_count
  );

  modport slave (
    input  rail_p, rail_n, init_value, clear_fault,
    output data_q, data_valid, fault, state, err_count
  );
endinterface : dual_rail_monitor_if
`default_nettype wire

// File: rtl/rail_sync.sv
`default_nettype none
// ============================================================================
// Module      : rail_sync
// Description : STAGES-deep synchroniser for a single rail. Every flop loads
//               rst_val_i while rstn is low, so the synchronised rail comes
//               out of reset already consistent with the data register.
//   clk        clock
//   rstn       asynchronous active-low reset
//   rst_val_i  value loaded into every stage during reset
//   d_i        asynchronous rail input
//   q_o        synchronised rail
// Revision    : 1.0  initial release
// ============================================================================
module rail_sync #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic rst_val_i,
  input  wire logic d_i,
  output logic      q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {STAGES{rst_val_i}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule : rail_sync
`default_nettype wire

// File: rtl/dual_rail_monitor.sv
`default_nettype none
// ============================================================================
// Module      : dual_rail_monitor
// Description : Synchronises a complementary rail pair, checks the pair stays
//               complementary, forwards the decoded bit and escalates runs of
//               invalid samples to a sticky FAULT state. FAULT entries are
//               counted in a saturating counter.
//   clk        clock (rising edge)
//   rstn       asynchronous active-low reset
//   bus        dual_rail_monitor_if.slave (rails, controls, status)
// Revision    : 1.0  initial release
// ============================================================================
module dual_rail_monitor
  import dual_rail_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int FAULT_THRESH = DEF_FAULT_THRESH,
  parameter int CNT_W        = 8
) (
  input wire logic           clk,
  input wire logic           rstn,
  dual_rail_monitor_if.slave bus
);

  localparam int RUN_W = run_cnt_w(FAULT_THRESH);

  logic             sp;
  logic             sn;
  logic             pair_ok;
  logic             init_n;

  state_e           state_q,     state_d;
  logic [RUN_W-1:0] run_cnt_q,   run_cnt_d;
  logic             bit_q,       bit_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  assign init_n = ~bus.init_value;

  rail_sync #(.STAGES(SYNC_STAGES)) u_sync_p (
    .clk       (clk),
    .rstn      (rstn),
    .rst_val_i (bus.init_value),
    .d_i       (bus.rail_p),
    .q_o       (sp)
  );

  rail_sync #(.STAGES(SYNC_STAGES)) u_sync_n (
    .clk       (clk),
    .rstn      (rstn),
    .rst_val_i (init_n),
    .d_i       (bus.rail_n),
    .q_o       (sn)
  );

  assign pair_ok = sp ^ sn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_OK;
      run_cnt_q   <= '0;
      bit_q       <= bus.init_value;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      bit_q       <= bit_d;
      err_count_q <= err_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    bit_d       = bit_q;
    err_count_d = err_count_q;
    case (state_q)
      ST_OK: begin
        if (pair_ok) begin
          bit_d = sp;
        end else begin
          state_d   = ST_SUSPECT;
          run_cnt_d = RUN_W'(1);
        end
      end
      ST_SUSPECT: begin
        if (pair_ok) begin
          state_d   = ST_OK;
          run_cnt_d = '0;
          bit_d     = sp;
        end else if (run_cnt_q == RUN_W'(FAULT_THRESH - 1)) begin
          // This sample completes the run: escalate, count the entry.
          state_d = ST_FAULT;
          if (err_count_q != {CNT_W{1'b1}}) begin
            err_count_d = err_count_q + 1'b1;
          end
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
      end
      ST_FAULT: begin
        if (bus.clear_fault && pair_ok) begin
          state_d   = ST_OK;
          run_cnt_d = '0;
          bit_d     = sp;
        end
      end
      default: begin
        // Unreachable encoding: fail safe without counting an event.
        state_d = ST_FAULT;
      end
    endcase
  end

  assign bus.data_q     = bit_q;
  assign bus.data_valid = (state_q == ST_OK);
  assign bus.fault      = (state_q == ST_FAULT);
  assign bus.state      = state_q;
  assign bus.err_count  = err_count_q;

endmodule : dual_rail_monitor
`default_nettype wire

// File: tb/tb_dual_rail_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_rail_monitor
// Description : Directed self-checking bench for dual_rail_monitor with
//               SYNC_STAGES=2, FAULT_THRESH=4, CNT_W=8.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dual_rail_monitor;

  logic clk;
  logic rstn;
  int   n_vec;
  int   n_err;

  dual_rail_monitor_if #(.CNT_W(8)) bus ();

  dual_rail_monitor #(
    .SYNC_STAGES  (2),
    .FAULT_THRESH (4),
    .CNT_W        (8)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rails(input logic p, input logic n);
    bus.rail_p = p;
    bus.rail_n = n;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn            = 1'b1;
    bus.init_value  = 1'b1;
    bus.clear_fault = 1'b0;
    set_rails(1'b1, 1'b0);

    // 1. Reset state with init_value=1
    #1 rstn = 1'b0;
    tick(2);
    check_vec("rst_data_q",  32'(bus.data_q),     32'd1);
    check_vec("rst_valid",   32'(bus.data_valid), 32'd1);
    check_vec("rst_fault",   32'(bus.fault),      32'd0);
    check_vec("rst_err",     32'(bus.err_count),  32'd0);
    check_vec("rst_state",   32'(bus.state),      32'd0);
    check_vec("rst_sync_p",  32'(dut.u_sync_p.sync_q), 32'h3);
    check_vec("rst_sync_n",  32'(dut.u_sync_n.sync_q), 32'h0);
    rstn = 1'b1;
    tick(3);
    check_vec("post_rst_data_q", 32'(bus.data_q),     32'd1);
    check_vec("post_rst_valid",  32'(bus.data_valid), 32'd1);

    // 2. Rail edge to data_q latency: 3 clocks
    set_rails(1'b0, 1'b1);
    tick(2);
    check_vec("lat_data_q_early", 32'(bus.data_q), 32'd1);
    tick(1);
    check_vec("lat_data_q",       32'(bus.data_q),     32'd0);
    check_vec("lat_valid",        32'(bus.data_valid), 32'd1);

    // 3. Two-clock invalid glitch -> two SUSPECT cycles, then OK
    set_rails(1'b1, 1'b1);
    tick(2);
    set_rails(1'b1, 1'b0);
    tick(1);
    check_vec("sus1_state",  32'(bus.state),      32'd1);
    check_vec("sus1_valid",  32'(bus.data_valid), 32'd0);
    check_vec("sus1_data_q", 32'(bus.data_q),     32'd0);
    tick(1);
    check_vec("sus2_state",  32'(bus.state),      32'd1);
    check_vec("sus2_data_q", 32'(bus.data_q),     32'd0);
    tick(1);
    check_vec("sus_exit_state",  32'(bus.state),  32'd0);
    check_vec("sus_exit_data_q", 32'(bus.data_q), 32'd1);
    check_vec("sus_exit_fault",  32'(bus.fault),  32'd0);

    // 4. Sustained invalid -> FAULT on 4th invalid sample
    set_rails(1'b0, 1'b0);
    tick(5);
    check_vec("pre_fault_state", 32'(bus.state), 32'd1);
    check_vec("pre_fault_fault", 32'(bus.fault), 32'd0);
    tick(1);
    check_vec("fault_set",   32'(bus.fault),     32'd1);
    check_vec("fault_err1",  32'(bus.err_count), 32'd1);
    bus.clear_fault = 1'b1;
    tick(1);
    bus.clear_fault = 1'b0;
    check_vec("clr_invalid_state", 32'(bus.state), 32'd2);
    set_rails(1'b0, 1'b1);
    tick(2);
    check_vec("sticky_state", 32'(bus.state), 32'd2);
    bus.clear_fault = 1'b1;
    tick(1);
    bus.clear_fault = 1'b0;
    check_vec("clr_ok_state",  32'(bus.state),      32'd0);
    check_vec("clr_ok_data_q", 32'(bus.data_q),     32'd0);
    check_vec("clr_ok_valid",  32'(bus.data_valid), 32'd1);
    check_vec("clr_ok_err",    32'(bus.err_count),  32'd1);

    // 5. Saturation of err_count over 300 total FAULT entries
    for (int k = 1; k <= 299; k++) begin
      set_rails(1'b1, 1'b1);
      tick(6);
      set_rails(1'b1, 1'b0);
      tick(2);
      bus.clear_fault = 1'b1;
      tick(1);
      bus.clear_fault = 1'b0;
      if (k == 199) check_vec("err_200", 32'(bus.err_count), 32'd200);
    end
    check_vec("sat_err",   32'(bus.err_count), 32'd255);
    check_vec("sat_state", 32'(bus.state),     32'd0);
    check_vec("sat_data_q", 32'(bus.data_q),   32'd1);

    // 6. Async reset while in FAULT, init_value=0
    set_rails(1'b0, 1'b0);
    tick(6);
    check_vec("f6_fault", 32'(bus.fault),     32'd1);
    check_vec("f6_err",   32'(bus.err_count), 32'd255);
    bus.init_value = 1'b0;
    #1 rstn = 1'b0;
    #1;
    check_vec("arst_state",  32'(bus.state),      32'd0);
    check_vec("arst_data_q", 32'(bus.data_q),     32'd0);
    check_vec("arst_fault",  32'(bus.fault),      32'd0);
    check_vec("arst_valid",  32'(bus.data_valid), 32'd1);
    check_vec("arst_err",    32'(bus.err_count),  32'd0);
    check_vec("arst_sync_p", 32'(dut.u_sync_p.sync_q), 32'h0);
    check_vec("arst_sync_n", 32'(dut.u_sync_n.sync_q), 32'h3);
    set_rails(1'b0, 1'b1);
    tick(1);
    rstn = 1'b1;
    tick(4);
    check_vec("rel_state",  32'(bus.state),  32'd0);
    check_vec("rel_data_q", 32'(bus.data_q), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dual_rail_monitor
`default_nettype wire
